// File: rtl/key_evt_pkg.sv
// Shared constants and the key-index-to-event-code mapping for the key event arbiter.
package key_evt_pkg;
   localparam logic [3:0] KEY_PREFIX    = 4'hA;
   localparam int         DEFAULT_NKEY  = 4;
   localparam int         DEFAULT_DEPTH = 4;

   function automatic logic [7:0] key_code(input logic [2:0] idx);
      return {KEY_PREFIX, 1'b0, idx};
   endfunction
endpackage

// File: rtl/key_evt_fifo.sv
// First-word-fall-through event FIFO, 8 bits wide; pop_data shows the oldest entry while valid.
module key_evt_fifo
   import key_evt_pkg::*;
#(
   parameter int DEPTH = DEFAULT_DEPTH
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       push,
   input  logic [7:0] push_data,
   input  logic       pop,
   output logic [7:0] pop_data,
   output logic       valid,
   output logic       full,
   output logic [4:0] count
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [7:0]    mem_q [DEPTH];
   logic [7:0]    mem_d [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [4:0]    count_q, count_d;
   logic          do_push, do_pop;

   // Push is gated on the current count only, so a same-cycle pop never opens room in a full FIFO.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      do_push  = push && (count_q < 5'(DEPTH));
      do_pop   = pop && (count_q != 5'd0);
      if (do_push) begin
         mem_d[wr_ptr_q] = push_data;
         wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      if (do_push && !do_pop) begin
         count_d = count_q + 5'd1;
      end else if (!do_push && do_pop) begin
         count_d = count_q - 5'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= 8'h00;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= 5'd0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign valid    = (count_q != 5'd0);
   assign full     = (count_q == 5'(DEPTH));
   assign count    = count_q;
   assign pop_data = valid ? mem_q[rd_ptr_q] : 8'h00;
endmodule

// File: rtl/key_event_arbiter.sv
// Latches key press pulses as pending bits and queues one round-robin grant per cycle into an event FIFO.
// Optional overflow flag and drop counter are compiled in with KEY_EVT_OVERFLOW_EN.
module key_event_arbiter
   import key_evt_pkg::*;
#(
   parameter int NKEY  = DEFAULT_NKEY,
   parameter int DEPTH = DEFAULT_DEPTH
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [NKEY-1:0] key_flag,
   output logic            evt_valid,
   input  logic            evt_ready,
   output logic [7:0]      evt_code,
`ifdef KEY_EVT_OVERFLOW_EN
   output logic [4:0]      evt_count,
   output logic            ovf,
   output logic [7:0]      drop_cnt
`else
   output logic [4:0]      evt_count
`endif
);
   logic [NKEY-1:0] pending_q, pending_d;
   logic [2:0]      rr_q, rr_d;
   logic [7:0]      pend8;
   logic [3:0]      scan;
   logic [2:0]      gnt_idx;
   logic            gnt_valid;
   logic [NKEY-1:0] gnt_vec;
   logic            fifo_full;

   always_comb begin
      pend8     = 8'(pending_q);
      gnt_valid = 1'b0;
      gnt_idx   = 3'd0;
      gnt_vec   = '0;
      scan      = 4'd0;
      rr_d      = rr_q;
      if (!fifo_full) begin
         for (int k = 0; k < NKEY; k++) begin
            scan = 4'(rr_q) + 4'(k);
            if (scan >= 4'(NKEY)) scan = scan - 4'(NKEY);
            if (!gnt_valid && pend8[scan[2:0]]) begin
               gnt_valid = 1'b1;
               gnt_idx   = scan[2:0];
            end
         end
      end
      if (gnt_valid) begin
         gnt_vec = NKEY'(1) << gnt_idx;
         rr_d    = (gnt_idx == 3'(NKEY - 1)) ? 3'd0 : gnt_idx + 3'd1;
      end
      // A fresh pulse on the granted key re-arms its pending bit for a new event.
      pending_d = (pending_q & ~gnt_vec) | key_flag;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending_q <= '0;
         rr_q      <= 3'd0;
      end else begin
         pending_q <= pending_d;
         rr_q      <= rr_d;
      end
   end

   key_evt_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (gnt_valid),
      .push_data (key_code(gnt_idx)),
      .pop       (evt_ready),
      .pop_data  (evt_code),
      .valid     (evt_valid),
      .full      (fifo_full),
      .count     (evt_count)
   );

`ifdef KEY_EVT_OVERFLOW_EN
   logic [NKEY-1:0] lost;
   logic [3:0]      lost_n;
   logic [8:0]      drop_sum;
   logic            ovf_q, ovf_d;
   logic [7:0]      drop_cnt_q, drop_cnt_d;

   // A pulse that lands on an already-pending, ungranted key is coalesced and counted as lost.
   always_comb begin
      lost   = key_flag & pending_q & ~gnt_vec;
      lost_n = 4'd0;
      for (int i = 0; i < NKEY; i++) lost_n = lost_n + 4'(lost[i]);
      drop_sum   = 9'(drop_cnt_q) + 9'(lost_n);
      drop_cnt_d = (drop_sum > 9'd255) ? 8'hFF : drop_sum[7:0];
      ovf_d      = ovf_q | (|lost);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_q      <= 1'b0;
         drop_cnt_q <= 8'h00;
      end else begin
         ovf_q      <= ovf_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   assign ovf      = ovf_q;
   assign drop_cnt = drop_cnt_q;
`endif
endmodule

// File: tb/tb_key_event_arbiter.sv
// Directed bench for key_event_arbiter with a queue-based reference model checked every cycle.
module tb_key_event_arbiter;
   localparam int NKEY  = 4;
   localparam int DEPTH = 4;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [NKEY-1:0] key_flag = '0;
   logic            evt_ready = 1'b0;
   logic            evt_valid;
   logic [7:0]      evt_code;
   logic [4:0]      evt_count;
`ifdef KEY_EVT_OVERFLOW_EN
   logic            ovf;
   logic [7:0]      drop_cnt;
`endif

   key_event_arbiter #(.NKEY(NKEY), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .key_flag  (key_flag),
      .evt_valid (evt_valid),
      .evt_ready (evt_ready),
      .evt_code  (evt_code),
`ifdef KEY_EVT_OVERFLOW_EN
      .evt_count (evt_count),
      .ovf       (ovf),
      .drop_cnt  (drop_cnt)
`else
      .evt_count (evt_count)
`endif
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // Reference model state
   logic [7:0]      exp_q[$];
   logic [NKEY-1:0] m_pend;
   int              m_rr;
   logic            m_ovf;
   int              m_drop;

   logic [7:0] got_q[$];
   logic       prev_stall;
   logic [7:0] prev_code;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_got(input string name, input logic [7:0] e[$]);
      check({name, "_len"}, 32'(got_q.size()), 32'(e.size()));
      for (int i = 0; i < e.size(); i++) begin
         check(name, (i < got_q.size()) ? 32'(got_q[i]) : 32'hFFFF, 32'(e[i]));
      end
   endtask

   task automatic m_clear();
      exp_q.delete();
      m_pend = '0;
      m_rr   = 0;
      m_ovf  = 1'b0;
      m_drop = 0;
   endtask

   task automatic model_step();
      int  g;
      int  lost;
      bit  pop;
      if (!rst_n) begin
         m_clear();
      end else begin
         pop  = evt_ready && (exp_q.size() > 0);
         g    = -1;
         lost = 0;
         if (exp_q.size() < DEPTH) begin
            for (int k = 0; k < NKEY; k++) begin
               if (g < 0 && m_pend[(m_rr + k) % NKEY]) g = (m_rr + k) % NKEY;
            end
         end
         for (int i = 0; i < NKEY; i++) begin
            if (key_flag[i] && m_pend[i] && i != g) lost++;
         end
         for (int i = 0; i < NKEY; i++) begin
            if (key_flag[i]) m_pend[i] = 1'b1;
            else if (i == g) m_pend[i] = 1'b0;
         end
         if (pop) void'(exp_q.pop_front());
         if (g >= 0) begin
            exp_q.push_back(8'hA0 + 8'(g));
            m_rr = (g + 1) % NKEY;
         end
         if (lost > 0) m_ovf = 1'b1;
         m_drop = (m_drop + lost > 255) ? 255 : m_drop + lost;
      end
   endtask

   initial begin
      m_clear();
      forever begin
         @(posedge clk or negedge rst_n);
         model_step();
      end
   end

   // Per-cycle comparison, stall-hold check and accepted-event log
   initial begin
      prev_stall = 1'b0;
      prev_code  = 8'h00;
      forever begin
         @(negedge clk);
         check("evt_valid", 32'(evt_valid), 32'(exp_q.size() > 0));
         check("evt_count", 32'(evt_count), 32'(exp_q.size()));
         check("evt_code", 32'(evt_code), (exp_q.size() > 0) ? 32'(exp_q[0]) : 32'h0);
`ifdef KEY_EVT_OVERFLOW_EN
         check("ovf", 32'(ovf), 32'(m_ovf));
         check("drop_cnt", 32'(drop_cnt), 32'(m_drop));
`endif
         if (rst_n && prev_stall && evt_valid) check("stall_hold", 32'(evt_code), 32'(prev_code));
         prev_stall = rst_n && evt_valid && !evt_ready;
         prev_code  = evt_code;
         if (rst_n && evt_valid && evt_ready) got_q.push_back(evt_code);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse(input logic [NKEY-1:0] k);
      key_flag = k;
      tick();
      key_flag = '0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      got_q.delete();
   endtask

   initial begin
      logic [NKEY-1:0] seq [6];
      seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};

      // Reset state
      repeat (3) tick();
      check("rst_valid", 32'(evt_valid), 32'd0);
      check("rst_count", 32'(evt_count), 32'd0);
      check("rst_code", 32'(evt_code), 32'h00);
      rst_n = 1'b1;

      // Single event latency
      evt_ready = 1'b1;
      repeat (8) tick();
      pulse(4'b0100);
      check("single_n1_valid", 32'(evt_valid), 32'd0);
      tick();
      check("single_n2_valid", 32'(evt_valid), 32'd1);
      check("single_n2_code", 32'(evt_code), 32'hA2);
      check("single_n2_count", 32'(evt_count), 32'd1);
      tick();
      check("single_n3_valid", 32'(evt_valid), 32'd0);
      check("single_n3_count", 32'(evt_count), 32'd0);
      check_got("single_got", '{8'hA2});

      // Round-robin order and wrap
      do_reset();
      evt_ready = 1'b0;
      pulse(4'b1111);
      repeat (5) tick();
      check("rr_count", 32'(evt_count), 32'd4);
      check("rr_head", 32'(evt_code), 32'hA0);
      evt_ready = 1'b1;
      repeat (6) tick();
      check_got("rr_order", '{8'hA0, 8'hA1, 8'hA2, 8'hA3});
      got_q.delete();
      pulse(4'b0011);
      repeat (5) tick();
      check_got("rr_wrap", '{8'hA0, 8'hA1});

      // Full FIFO with keys left pending
      do_reset();
      evt_ready = 1'b0;
      for (int i = 0; i < 6; i++) pulse(seq[i]);
      repeat (3) tick();
      check("full_count", 32'(evt_count), 32'd4);
      evt_ready = 1'b1;
      tick();
      tick();
      evt_ready = 1'b0;
      tick();
      check("full_refill_count", 32'(evt_count), 32'd4);
      check("full_refill_head", 32'(evt_code), 32'hA2);
      check_got("full_popped", '{8'hA0, 8'hA1});
      got_q.delete();
      evt_ready = 1'b1;
      repeat (6) tick();
      check_got("full_drain", '{8'hA2, 8'hA3, 8'hA0, 8'hA1});

      // Coalescing while full
      do_reset();
      evt_ready = 1'b0;
      pulse(4'b1111);
      repeat (5) tick();
      repeat (3) pulse(4'b0100);
`ifdef KEY_EVT_OVERFLOW_EN
      check("coal_ovf", 32'(ovf), 32'd1);
      check("coal_drop", 32'(drop_cnt), 32'd2);
`endif
      pulse(4'b1111);
      pulse(4'b1111);
      tick();
`ifdef KEY_EVT_OVERFLOW_EN
      check("coal_drop_multi", 32'(drop_cnt), 32'd7);
`endif
      check("coal_count", 32'(evt_count), 32'd4);
      evt_ready = 1'b1;
      repeat (12) tick();
      check_got("coal_drain", '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA0, 8'hA1, 8'hA2, 8'hA3});
`ifdef KEY_EVT_OVERFLOW_EN
      check("coal_ovf_sticky", 32'(ovf), 32'd1);
`endif

      // Backpressure with continuous pulses
      do_reset();
      for (int i = 0; i < 40; i++) begin
         key_flag  = 4'(i * 7 + 1);
         evt_ready = (i % 2) == 1;
         tick();
      end
      key_flag  = '0;
      evt_ready = 1'b1;
      repeat (20) tick();
      check("bp_drained", 32'(evt_count), 32'd0);

      // Reset mid-stream
      do_reset();
      evt_ready = 1'b0;
      pulse(4'b0111);
      repeat (3) tick();
      check("midrst_count_before", 32'(evt_count), 32'd3);
      rst_n = 1'b0;
      #1;
      check("midrst_valid", 32'(evt_valid), 32'd0);
      check("midrst_count", 32'(evt_count), 32'd0);
      check("midrst_code", 32'(evt_code), 32'h00);
      tick();
      rst_n    = 1'b1;
      key_flag = 4'b0010;
      tick();
      key_flag = '0;
      check("midrst_n1_valid", 32'(evt_valid), 32'd0);
      tick();
      check("midrst_n2_valid", 32'(evt_valid), 32'd1);
      check("midrst_n2_code", 32'(evt_code), 32'hA1);

      repeat (2) tick();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/key_event_arbiter.md
KEY_EVENT_ARBITER -- requirements
Module: key_event_arbiter

Interface
REQ-001 The block SHALL have parameter NKEY, default 4, meaning the number of key flag inputs (2..8).
REQ-002 The block SHALL have parameter DEPTH, default 4, meaning the event FIFO depth (power of 2, 2..16).
REQ-003 The block SHALL have port clk  input  1  meaning the single system clock; all logic runs on its rising edge.
REQ-004 The block SHALL have port rst_n  input  1  meaning the reset, asynchronous and active-low.
REQ-005 The block SHALL have port key_flag  input  NKEY  meaning one-cycle press pulses from the debouncer, one bit per key.
REQ-006 The block SHALL have port evt_valid  output  1  meaning a key event is presented on evt_code.
REQ-007 The block SHALL have port evt_ready  input  1  meaning the consumer (SPI transmit path) accepts the event.
REQ-008 The block SHALL have port evt_code  output  8  meaning the event code {4'hA, 1'b0, key index[2:0]}.
REQ-009 The block SHALL have port evt_count  output  5  meaning the number of events currently held in the FIFO.

Function
REQ-010 Each key SHALL own a pending bit, set at the rising edge that samples key_flag[i]=1.
REQ-011 When the FIFO is not full and at least one pending bit is set, the arbiter SHALL grant exactly one key per cycle, clear its pending bit and push its code.
REQ-012 Arbitration SHALL be round-robin: the search starts at pointer rr, which resets to 0 and becomes (granted index + 1) mod NKEY after each grant.
REQ-013 A pulse on key i in the same cycle that key i is granted SHALL leave pending[i] set, creating a new event.
REQ-014 A pulse on key i while pending[i] is set and not being granted SHALL be coalesced, and the event is lost.
REQ-015 Push SHALL occur only when evt_count < DEPTH; a pop in the same cycle SHALL NOT enable a push into a full FIFO.
REQ-016 The FIFO SHALL be first-word-fall-through: evt_valid=1 whenever evt_count>0, and evt_code shows the oldest entry.
REQ-017 A pop SHALL occur on a rising edge with evt_valid=1 and evt_ready=1; simultaneous push and pop SHALL leave evt_count unchanged.
REQ-018 Latency SHALL be as follows: for an isolated pulse during cycle N with the FIFO empty, evt_valid=1 from cycle N+2, with the code of that key.
REQ-019 evt_code SHALL hold its value while evt_valid=1 and evt_ready=0.
REQ-020 FIFO read/write pointers SHALL wrap modulo DEPTH; evt_count SHALL range 0..DEPTH.

Reset
REQ-021 While rst_n=0, the block SHALL force pending=0, rr=0, FIFO pointers=0, evt_count=0, evt_valid=0, evt_code=8'h00 (and ovf=0, drop_cnt=0 when the overflow feature is compiled in).
REQ-022 Reset asserted mid-operation SHALL discard all queued and pending events without emitting a partial event.
REQ-023 The first rising edge after rst_n deasserts SHALL already sample key_flag.

Configuration
REQ-024 With macro KEY_EVT_OVERFLOW_EN defined, the block SHALL add output port ovf (1 bit), a sticky flag set on any event lost per REQ-014, and output port drop_cnt (8 bits), which saturates at 8'hFF.
REQ-025 When two or more events are lost in the same cycle, drop_cnt SHALL increment by the number of lost events, saturating at 8'hFF.
REQ-026 ovf and drop_cnt SHALL clear only on reset.
REQ-027 Without KEY_EVT_OVERFLOW_EN, the ovf and drop_cnt ports and their logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-028 Shared package key_evt_pkg SHALL hold the code prefix constant 4'hA, the default NKEY/DEPTH values, and a function mapping key index to an 8-bit code.
REQ-029 The FIFO SHALL be a sub-module key_evt_fifo (FWFT, parameter DEPTH, width 8, push/pop/count).
REQ-030 The pending register, round-robin arbiter and overflow counter SHALL reside in key_event_arbiter.

Verification
REQ-031 The bench SHALL verify the single event case: key_flag=4'b0100 for 1 cycle at cycle 10 with evt_ready=1 -> evt_valid=1 in cycle 12 only, evt_code=8'hA2, evt_count returns to 0.
REQ-032 The bench SHALL verify round-robin: key_flag=4'b1111 for 1 cycle with evt_ready=0 -> FIFO order A0,A1,A2,A3; then pulse 4'b0011 after draining -> order A0,A1 (rr wrapped to 0).
REQ-033 The bench SHALL verify full FIFO: 6 distinct pulses (keys 0,1,2,3,0,1, one per cycle) with DEPTH=4 and evt_ready=0 -> evt_count=4, pending=4'b0011; after 2 pops, A0 and A1 are queued, evt_count=4.
REQ-034 The bench SHALL verify coalescing: with KEY_EVT_OVERFLOW_EN, FIFO full, key 2 pulsed 3 times -> one pending event, ovf=1, drop_cnt=2.
REQ-035 The bench SHALL verify backpressure plus simultaneous events: evt_ready toggling every cycle under continuous pulses -> evt_code stable while stalled, no duplicated or reordered codes versus a reference model.
REQ-036 The bench SHALL verify reset mid-stream: rst_n=0 with evt_count=3 -> evt_valid=0 and evt_count=0 immediately, and the next pulse on key 1 yields A1 two cycles later.
